// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the E0C6S46-compatible core sequencer: instruction
// lengths, microcode slot actions, sequencer states and period constants.
package cpu_sequencer_pkg;

    // Instruction period length reported by the decoder.
    typedef enum logic [1:0] {
        CYCLE5,
        CYCLE7,
        CYCLE12
    } instr_length;

    // Register/ALU datapath action for one microcode slot.
    typedef enum logic [1:0] {
        CYCLE_NONE,
        CYCLE_REG_FETCH,
        CYCLE_REG_WRITE,
        CYCLE_ALU
    } microcode_cycle;

    // Sequencer period phases.
    typedef enum logic [2:0] {
        SEQ_FETCH,
        SEQ_DECODE,
        SEQ_EXEC,
        SEQ_IRQ,
        SEQ_HALT
    } seq_state;

    localparam int IRQ_CYCLES       = 12;
    localparam int MICRO_SLOT_COUNT = 4;

    // Number of ticks in an instruction period of the given length.
    function automatic int cycle_count_int(input instr_length len);
        case (len)
            CYCLE5:  return 5;
            CYCLE7:  return 7;
            default: return 12;
        endcase
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Per-instruction cycle sequencer. Counts clk_en ticks through FETCH, DECODE
// and EXEC, issues the decoder's microcode slots, and handles HALT and the
// 12-tick interrupt entry period.
// Optional feature macro: SEQ_SINGLE_STEP_EN (single-step hold in FETCH).
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int MICRO_SLOTS = MICRO_SLOT_COUNT
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                clk_en,
    input  instr_length                         length,
    input  microcode_cycle [MICRO_SLOTS-1:0]    micro_slots,
    input  logic                                halt_req,
    input  logic                                irq_pending,
    input  logic                                irq_enable,
    input  logic                                step_mode,
    input  logic                                step_pulse,
    output logic                                fetch_strobe,
    output logic                                decode_strobe,
    output microcode_cycle                      micro_cycle,
    output logic [1:0]                          micro_index,
    output logic                                instr_done,
    output logic                                irq_ack,
    output logic                                irq_service,
    output logic                                halted,
    output logic [3:0]                          tick
);

    seq_state                          state;
    seq_state                          next_state;
    logic [3:0]                        tick_q;
    logic [3:0]                        next_tick;
    instr_length                       len_q;
    logic [MICRO_SLOTS-1:0][1:0]       slots_q;
    logic                              halt_q;

    logic [3:0]                        last_tick;
    logic [3:0]                        slot_off;
    logic                              slot_issue;
    logic                              fetch_go;

    assign last_tick  = 4'(cycle_count_int(len_q) - 1);
    assign slot_off   = tick_q - 4'd2;
    assign slot_issue = (state == SEQ_EXEC) && (slot_off < 4'(MICRO_SLOTS));

`ifdef SEQ_SINGLE_STEP_EN
    // In step mode FETCH is held at tick 0 until a step request arrives.
    assign fetch_go = !step_mode || step_pulse;
`else
    assign fetch_go = 1'b1;
    logic unused_step;
    assign unused_step = step_mode ^ step_pulse;
`endif

    // State, tick counter and decode-time latches.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state   <= SEQ_FETCH;
            tick_q  <= 4'd0;
            len_q   <= CYCLE5;
            slots_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            state  <= next_state;
            tick_q <= next_tick;
            if (clk_en && state == SEQ_DECODE) begin
                len_q   <= length;
                slots_q <= micro_slots;
                halt_q  <= halt_req;
            end
        end
    end

    // Next-state/tick and clk_en-qualified strobes.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        next_state    = state;
        next_tick     = tick_q;
        fetch_strobe  = 1'b0;
        decode_strobe = 1'b0;
        micro_cycle   = CYCLE_NONE;
        micro_index   = 2'd0;
        instr_done    = 1'b0;
        irq_ack       = 1'b0;
        irq_service   = 1'b0;
        if (clk_en) begin
            case (state)
                SEQ_FETCH: begin
                    if (fetch_go) begin
                        fetch_strobe = 1'b1;
                        next_state   = SEQ_DECODE;
                        next_tick    = 4'd1;
                    end
                end
                SEQ_DECODE: begin
                    decode_strobe = 1'b1;
                    next_state    = SEQ_EXEC;
                    next_tick     = 4'd2;
                end
                SEQ_EXEC: begin
                    if (slot_issue) begin
                        micro_cycle = microcode_cycle'(slots_q[slot_off[1:0]]);
                        micro_index = slot_off[1:0];
                    end
                    if (tick_q == last_tick) begin
                        // Interrupt beats a latched HALT; the halt is then dropped.
                        instr_done = 1'b1;
                        next_tick  = 4'd0;
                        if (irq_pending && irq_enable)
                            next_state = SEQ_IRQ;
                        else if (halt_q)
                            next_state = SEQ_HALT;
                        else
                            next_state = SEQ_FETCH;
                    end else begin
                        next_tick = tick_q + 4'd1;
                    end
                end
                SEQ_IRQ: begin
                    irq_service = 1'b1;
                    irq_ack     = (tick_q == 4'd0);
                    if (tick_q == 4'(IRQ_CYCLES - 1)) begin
                        instr_done = 1'b1;
                        next_state = SEQ_FETCH;
                        next_tick  = 4'd0;
                    end else begin
                        next_tick = tick_q + 4'd1;
                    end
                end
                SEQ_HALT: begin
                    // Wakeup ignores the I flag.
                    next_tick = 4'd0;
                    if (irq_pending)
                        next_state = SEQ_IRQ;
                end
                default: begin
                    next_state = SEQ_FETCH;
                    next_tick  = 4'd0;
                end
            endcase
        end
    end

    assign halted = (state == SEQ_HALT);
    assign tick   = tick_q;

endmodule
